// File: rtl/ccu_cmp_ctrl_pkg.sv
// Shared constants for the timer-2 compare/reload controller:
// SFR addresses, T2CON bit positions, mode codes and channel address helpers.
package ccu_cmp_ctrl_pkg;

    localparam int NUM_CH = 4;

    // SFR addresses, 7 LSBs of the 80h-FFh SFR space
    localparam logic [6:0] SFR_CCEN  = 7'h41;
    localparam logic [6:0] SFR_CCL1  = 7'h42;
    localparam logic [6:0] SFR_CCH1  = 7'h43;
    localparam logic [6:0] SFR_CCL2  = 7'h44;
    localparam logic [6:0] SFR_CCH2  = 7'h45;
    localparam logic [6:0] SFR_CCL3  = 7'h46;
    localparam logic [6:0] SFR_CCH3  = 7'h47;
    localparam logic [6:0] SFR_T2CON = 7'h48;
    localparam logic [6:0] SFR_CRCL  = 7'h4A;
    localparam logic [6:0] SFR_CRCH  = 7'h4B;
    localparam logic [6:0] SFR_TL2   = 7'h4C;
    localparam logic [6:0] SFR_TH2   = 7'h4D;

    // T2CON field positions
    localparam int T2I_LSB  = 0;
    localparam int T2CM_BIT = 2;
    localparam int T2R_LSB  = 3;
    localparam int TF2_BIT  = 6;
    localparam int T2PS_BIT = 7;

    localparam logic [1:0] T2I_RUN  = 2'b01;
    localparam logic [1:0] T2R_AUTO = 2'b10;
    localparam logic [1:0] COMP_EN  = 2'b10;

    // Channel 0 is the reload register CRC, channels 1..3 are CC1..CC3
    function automatic logic [6:0] ch_lo_addr(input int ch);
        case (ch)
            0:       return SFR_CRCL;
            1:       return SFR_CCL1;
            2:       return SFR_CCL2;
            default: return SFR_CCL3;
        endcase
    endfunction

    function automatic logic [6:0] ch_hi_addr(input int ch);
        case (ch)
            0:       return SFR_CRCH;
            1:       return SFR_CCH1;
            2:       return SFR_CCH2;
            default: return SFR_CCH3;
        endcase
    endfunction

endpackage

// File: rtl/ccu_cmp_reg16.sv
// 16-bit register loaded atomically: low byte parks in a shadow until the high-byte write.
// Equality against the compare value is combinational; the caller decides when it counts.
module ccu_cmp_reg16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [7:0]  wdat,
    input  logic [15:0] cmp_val,
    output logic [15:0] value,
    output logic        match
);

    logic [7:0] shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            value  <= '0;
        end else begin
            if (wr_lo) begin
                shadow <= wdat;
            end
            if (wr_hi) begin
                value <= {wdat, shadow};
            end
        end
    end

    assign match = (value == cmp_val);

endmodule

// File: rtl/ccu_cmp_ctrl.sv
// Timer-2 compare/reload controller: prescaled 16-bit timer with auto-reload, four compare
// channels and an overflow pulse, plus the SFR write decode and read mux for its registers.
module ccu_cmp_ctrl
    import ccu_cmp_ctrl_pkg::*;
#(
    parameter int PRE_SLOW = 24,
    parameter int PRE_FAST = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        sfrdatai,
    input  logic [6:0]        sfraddr,
    input  logic              sfrwe,
    output logic [7:0]        sfrdatao,
    output logic [NUM_CH-1:0] compare,
    output logic              ov,
    output logic [7:0]        cocahl,
    output logic              t2cm,
    output logic              tf2
);

    localparam int PRE_DIV_MAX = (PRE_SLOW > PRE_FAST) ? PRE_SLOW : PRE_FAST;
    localparam int PW          = $clog2(PRE_DIV_MAX + 1);

    logic [7:0]        t2con;
    logic [7:0]        ccen;
    logic [15:0]       tmr;
    logic [PW-1:0]     pre;
    logic [PW-1:0]     pre_max;
    logic [15:0]       cc_val [NUM_CH];
    logic [NUM_CH-1:0] cc_match;

    logic        run;
    logic        tick;
    logic        t2con_wr;
    logic        ccen_wr;
    logic        tl2_wr;
    logic        th2_wr;
    logic        tmr_upd;
    logic        ovf_evt;
    logic [15:0] tmr_next;

    assign t2con_wr = sfrwe && (sfraddr == SFR_T2CON);
    assign ccen_wr  = sfrwe && (sfraddr == SFR_CCEN);
    assign tl2_wr   = sfrwe && (sfraddr == SFR_TL2);
    assign th2_wr   = sfrwe && (sfraddr == SFR_TH2);

    assign run     = (t2con[T2I_LSB +: 2] == T2I_RUN);
    assign pre_max = t2con[T2PS_BIT] ? PW'(PRE_SLOW - 1) : PW'(PRE_FAST - 1);
    assign tick    = run && (pre == pre_max);

    // A software write to the count pre-empts the tick: no increment, overflow or compare
    assign tmr_upd = tick && !(tl2_wr || th2_wr);
    assign ovf_evt = tmr_upd && (tmr == 16'hFFFF);

    always_comb begin
        tmr_next = tmr + 16'd1;
        if (tmr == 16'hFFFF) begin
            tmr_next = (t2con[T2R_LSB +: 2] == T2R_AUTO) ? cc_val[0] : 16'h0000;
        end
    end

    // Comparators see the value the timer is about to take, so the pulse lines up with ov
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ccu_cmp_reg16 u_reg (
            .clk     (clk),
            .rst     (rst),
            .wr_lo   (sfrwe && (sfraddr == ch_lo_addr(i))),
            .wr_hi   (sfrwe && (sfraddr == ch_hi_addr(i))),
            .wdat    (sfrdatai),
            .cmp_val (tmr_next),
            .value   (cc_val[i]),
            .match   (cc_match[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t2con <= '0;
            ccen  <= '0;
        end else begin
            if (t2con_wr) begin
                t2con <= sfrdatai;
            end
            // Hardware set beats a same-cycle software clear
            if (ovf_evt) begin
                t2con[TF2_BIT] <= 1'b1;
            end
            if (ccen_wr) begin
                ccen <= sfrdatai;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if (t2con_wr && (sfrdatai[T2PS_BIT] != t2con[T2PS_BIT])) begin
            pre <= '0;
        end else if (run) begin
            pre <= (pre == pre_max) ? '0 : pre + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr <= '0;
        end else if (tl2_wr) begin
            tmr[7:0] <= sfrdatai;
        end else if (th2_wr) begin
            tmr[15:8] <= sfrdatai;
        end else if (tmr_upd) begin
            tmr <= tmr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ov      <= 1'b0;
            compare <= '0;
        end else begin
            ov <= ovf_evt;
            for (int i = 0; i < NUM_CH; i++) begin
                compare[i] <= tmr_upd && (ccen[2*i +: 2] == COMP_EN) && cc_match[i];
            end
        end
    end

    // The low-byte addresses return the active value, never the pending shadow
    always_comb begin
        sfrdatao = '0;
        case (sfraddr)
            SFR_T2CON: sfrdatao = t2con;
            SFR_CCEN:  sfrdatao = ccen;
            SFR_TL2:   sfrdatao = tmr[7:0];
            SFR_TH2:   sfrdatao = tmr[15:8];
            default:   ;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (sfraddr == ch_lo_addr(i)) begin
                sfrdatao = cc_val[i][7:0];
            end
            if (sfraddr == ch_hi_addr(i)) begin
                sfrdatao = cc_val[i][15:8];
            end
        end
    end

    assign cocahl = ccen;
    assign t2cm   = t2con[T2CM_BIT];
    assign tf2    = t2con[TF2_BIT];

endmodule

// File: tb/tb_ccu_cmp_ctrl.sv
// Self-checking bench for ccu_cmp_ctrl: register checks inline, compare/ov pulses
// checked against a scoreboard of expected (edge, ov, compare) entries.
module tb_ccu_cmp_ctrl;
    import ccu_cmp_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] sfrdatai;
    logic [6:0] sfraddr;
    logic       sfrwe;
    logic [7:0] sfrdatao;
    logic [3:0] compare;
    logic       ov;
    logic [7:0] cocahl;
    logic       t2cm;
    logic       tf2;

    ccu_cmp_ctrl #(.PRE_SLOW(24), .PRE_FAST(12)) dut (
        .clk      (clk),
        .rst      (rst),
        .sfrdatai (sfrdatai),
        .sfraddr  (sfraddr),
        .sfrwe    (sfrwe),
        .sfrdatao (sfrdatao),
        .compare  (compare),
        .ov       (ov),
        .cocahl   (cocahl),
        .t2cm     (t2cm),
        .tf2      (tf2)
    );

    typedef struct {
        int         cyc;
        logic       ov;
        logic [3:0] cmp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   wr_cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   mon_en = 0;
    int   c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        sfraddr  = a;
        sfrdatai = d;
        sfrwe    = 1'b1;
        @(posedge clk);
        #1;
        sfrwe  = 1'b0;
        wr_cyc = cyc;
    endtask

    task automatic rdchk(input string tag, input logic [6:0] a, input logic [7:0] exp);
        sfraddr = a;
        #1;
        chk(tag, sfrdatao, exp);
    endtask

    task automatic wait_to(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every pulse must match the head of the scoreboard, edge-exact
    always @(negedge clk) begin
        if (mon_en && (ov || (compare != 4'b0000))) begin
            if (sb.size() == 0) begin
                chk("pulse_unexpected", {27'd0, ov, compare}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_cyc", cyc, mon_e.cyc);
                chk("pulse_ov", ov, mon_e.ov);
                chk("pulse_cmp", compare, mon_e.cmp);
            end
        end
    end

    initial begin
        rst = 1'b1; sfrwe = 1'b0; sfraddr = '0; sfrdatai = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset state, then a register load and a one-cycle reset
        chk("rst_compare", compare, 4'h0);
        chk("rst_ov", ov, 1'b0);
        chk("rst_cocahl", cocahl, 8'h00);
        chk("rst_t2cm", t2cm, 1'b0);
        chk("rst_tf2", tf2, 1'b0);
        rdchk("rst_unowned", 7'h00, 8'h00);
        wr(SFR_CCEN, 8'hFF);
        wr(SFR_T2CON, 8'h04);
        chk("cocahl_wr", cocahl, 8'hFF);
        chk("t2cm_wr", t2cm, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst2_cocahl", cocahl, 8'h00);
        chk("rst2_t2cm", t2cm, 1'b0);
        rdchk("rst2_ccen", SFR_CCEN, 8'h00);
        rdchk("rst2_t2con", SFR_T2CON, 8'h00);

        // Count FFFE -> FFFF -> 0000 with the fast prescaler, overflow wraps to 0
        wr(SFR_T2CON, 8'h80);
        wr(SFR_TL2, 8'hFE);
        wr(SFR_TH2, 8'hFF);
        wr(SFR_T2CON, 8'h01);
        c = wr_cyc;
        sb.push_back('{cyc: c + 24, ov: 1'b1, cmp: 4'b0000});
        chk("t2_tf2_pre", tf2, 1'b0);
        wait_to(c + 11);
        rdchk("t2_tl2_hold", SFR_TL2, 8'hFE);
        wait_to(c + 12);
        rdchk("t2_tl2_ffff", SFR_TL2, 8'hFF);
        rdchk("t2_th2_ffff", SFR_TH2, 8'hFF);
        wait_to(c + 24);
        rdchk("t2_tl2_wrap", SFR_TL2, 8'h00);
        rdchk("t2_th2_wrap", SFR_TH2, 8'h00);
        chk("t2_tf2_set", tf2, 1'b1);
        wr(SFR_T2CON, 8'h80);
        chk("t2_sb_drain", sb.size(), 0);

        // Auto-reload to FFF0 lands on CC1 = FFF0: compare[1] together with ov
        wr(SFR_TL2, 8'hFF);
        wr(SFR_TH2, 8'hFF);
        wr(SFR_CRCL, 8'hF0);
        wr(SFR_CRCH, 8'hFF);
        wr(SFR_CCL1, 8'hF0);
        wr(SFR_CCH1, 8'hFF);
        wr(SFR_CCEN, 8'h08);
        rdchk("t3_crcl", SFR_CRCL, 8'hF0);
        rdchk("t3_cch1", SFR_CCH1, 8'hFF);
        wr(SFR_T2CON, 8'h11);
        c = wr_cyc;
        sb.push_back('{cyc: c + 12, ov: 1'b1, cmp: 4'b0010});
        wait_to(c + 12);
        rdchk("t3_tl2_reload", SFR_TL2, 8'hF0);
        rdchk("t3_th2_reload", SFR_TH2, 8'hFF);
        chk("t3_tf2", tf2, 1'b1);
        wr(SFR_T2CON, 8'h80);
        chk("t3_sb_drain", sb.size(), 0);

        // Half-written CC2 must not compare; after the high write one match at 1234
        wr(SFR_CCEN, 8'h20);
        wr(SFR_TL2, 8'h30);
        wr(SFR_TH2, 8'h00);
        wr(SFR_CCL2, 8'h34);
        rdchk("t4_ccl2_shadow", SFR_CCL2, 8'h00);
        wr(SFR_T2CON, 8'h01);
        c = wr_cyc;
        wait_to(c + 62);
        rdchk("t4_tl2_past", SFR_TL2, 8'h35);
        wr(SFR_CCH2, 8'h12);
        rdchk("t4_ccl2", SFR_CCL2, 8'h34);
        rdchk("t4_cch2", SFR_CCH2, 8'h12);
        wr(SFR_T2CON, 8'h80);
        wr(SFR_TL2, 8'h32);
        wr(SFR_TH2, 8'h12);
        wr(SFR_T2CON, 8'h01);
        c = wr_cyc;
        sb.push_back('{cyc: c + 24, ov: 1'b0, cmp: 4'b0100});
        wait_to(c + 50);
        rdchk("t4_tl2_end", SFR_TL2, 8'h36);
        wr(SFR_T2CON, 8'h80);
        chk("t4_sb_drain", sb.size(), 0);

        // TL2 write on the tick edge wins; TF2 clear on the overflow edge loses
        wr(SFR_CCEN, 8'h00);
        wr(SFR_TL2, 8'hFF);
        wr(SFR_TH2, 8'hFF);
        wr(SFR_T2CON, 8'h01);
        c = wr_cyc;
        chk("t5_tf2_clr", tf2, 1'b0);
        wait_to(c + 11);
        wr(SFR_TL2, 8'h55);
        chk("t5_wr_edge", wr_cyc, c + 12);
        rdchk("t5_tl2_held", SFR_TL2, 8'h55);
        rdchk("t5_th2_held", SFR_TH2, 8'hFF);
        chk("t5_tf2_noov", tf2, 1'b0);
        wr(SFR_T2CON, 8'h80);
        wr(SFR_TL2, 8'hFF);
        wr(SFR_T2CON, 8'h01);
        c = wr_cyc;
        sb.push_back('{cyc: c + 12, ov: 1'b1, cmp: 4'b0000});
        wait_to(c + 11);
        wr(SFR_T2CON, 8'h01);
        chk("t5_tf2_setwins", tf2, 1'b1);
        rdchk("t5_tl2_wrap", SFR_TL2, 8'h00);
        rdchk("t5_th2_wrap", SFR_TH2, 8'h00);
        wr(SFR_T2CON, 8'h80);
        chk("t5_sb_drain", sb.size(), 0);

        // Stopped timer sitting on CC3: frozen count, no compare
        wr(SFR_CCL3, 8'h77);
        wr(SFR_CCH3, 8'h00);
        wr(SFR_TL2, 8'h77);
        wr(SFR_TH2, 8'h00);
        wr(SFR_CCEN, 8'h80);
        wr(SFR_T2CON, 8'h00);
        c = wr_cyc;
        wait_to(c + 40);
        chk("t6_compare", compare, 4'h0);
        rdchk("t6_tl2_frozen", SFR_TL2, 8'h77);
        rdchk("t6_th2_frozen", SFR_TH2, 8'h00);
        chk("t6_sb_drain", sb.size(), 0);

        // Reset on the overflow edge suppresses the pulse and clears the count
        wr(SFR_T2CON, 8'h80);
        wr(SFR_TL2, 8'hFF);
        wr(SFR_TH2, 8'hFF);
        wr(SFR_T2CON, 8'h01);
        c = wr_cyc;
        wait_to(c + 11);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t7_ov", ov, 1'b0);
        chk("t7_tf2", tf2, 1'b0);
        rdchk("t7_tl2", SFR_TL2, 8'h00);
        rdchk("t7_th2", SFR_TH2, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("t7_sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
